// File: rtl/bypass_ctrl.sv
// Operand bypass and interlock controller: per-port forwarding mux, load-use/MDU stall, MDU busy timer.
// Optional stall-cycle counter enabled by defining BYPASS_STALL_CNT_EN; otherwise stall_cnt is tied to 0.
module bypass_ctrl #(
    parameter int NRP     = 2,
    parameter int DW      = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRP*5-1:0]  rd_addr,
    input  logic [NRP*2-1:0]  rd_tuse,
    input  logic [NRP*DW-1:0] rd_regval,
    input  logic [4:0]        e_waddr,
    input  logic [4:0]        m_waddr,
    input  logic [4:0]        w_waddr,
    input  logic [1:0]        e_tnew,
    input  logic [1:0]        m_tnew,
    input  logic [DW-1:0]     e_wdata,
    input  logic [DW-1:0]     m_wdata,
    input  logic [DW-1:0]     w_wdata,
    input  logic              mdu_start,
    input  logic              mdu_div,
    input  logic              d_is_mdu,
    output logic [NRP*DW-1:0] fwd_data,
    output logic              stall,
    output logic              mdu_busy,
    output logic [31:0]       stall_cnt
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    logic [NRP-1:0] port_haz;

    for (genvar k = 0; k < NRP; k++) begin : g_port
        logic [4:0] src;
        logic [1:0] tuse;
        logic       e_hit;
        logic       m_hit;
        logic       w_hit;

        assign src   = rd_addr[5*k +: 5];
        assign tuse  = rd_tuse[2*k +: 2];
        assign e_hit = (e_waddr == src) && (src != 5'd0);
        assign m_hit = (m_waddr == src) && (src != 5'd0);
        assign w_hit = (w_waddr == src) && (src != 5'd0);

        assign fwd_data[DW*k +: DW] =
            (e_hit && e_tnew == 2'd0) ? e_wdata :
            (m_hit && m_tnew == 2'd0) ? m_wdata :
            w_hit                     ? w_wdata :
                                        rd_regval[DW*k +: DW];

        // Only the youngest matching producer decides readiness; an older ready value is stale.
        assign port_haz[k] = e_hit ? (e_tnew > tuse) :
                             m_hit ? (m_tnew > tuse) : 1'b0;
    end

    logic [3:0] mdu_cnt_q, mdu_cnt_d;

    assign mdu_busy = (mdu_cnt_q != 4'd0);
    assign stall    = (|port_haz) || (d_is_mdu && (mdu_busy || mdu_start));

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (mdu_busy) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end else if (mdu_start) begin
            mdu_cnt_d = mdu_div ? DIV_CNT : MUL_CNT;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdu_cnt_q <= 4'd0;
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

`ifdef BYPASS_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bypass_ctrl.sv
// Directed self-checking bench for bypass_ctrl (default parameters NRP=2, DW=32, MUL_LAT=5, DIV_LAT=10).
module tb_bypass_ctrl;

    localparam int NRP = 2;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NRP*5-1:0]  rd_addr;
    logic [NRP*2-1:0]  rd_tuse;
    logic [NRP*DW-1:0] rd_regval;
    logic [4:0]        e_waddr, m_waddr, w_waddr;
    logic [1:0]        e_tnew, m_tnew;
    logic [DW-1:0]     e_wdata, m_wdata, w_wdata;
    logic              mdu_start, mdu_div, d_is_mdu;
    logic [NRP*DW-1:0] fwd_data;
    logic              stall, mdu_busy;
    logic [31:0]       stall_cnt;

    int checks   = 0;
    int failures = 0;

    bypass_ctrl #(.NRP(NRP), .DW(DW), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_tuse   (rd_tuse),
        .rd_regval (rd_regval),
        .e_waddr   (e_waddr),
        .m_waddr   (m_waddr),
        .w_waddr   (w_waddr),
        .e_tnew    (e_tnew),
        .m_tnew    (m_tnew),
        .e_wdata   (e_wdata),
        .m_wdata   (m_wdata),
        .w_wdata   (w_wdata),
        .mdu_start (mdu_start),
        .mdu_div   (mdu_div),
        .d_is_mdu  (d_is_mdu),
        .fwd_data  (fwd_data),
        .stall     (stall),
        .mdu_busy  (mdu_busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        rd_addr   = '0;
        rd_tuse   = '0;
        rd_regval = {32'h5555_0001, 32'h5555_0000};
        e_waddr   = 5'd0;
        m_waddr   = 5'd0;
        w_waddr   = 5'd0;
        e_tnew    = 2'd0;
        m_tnew    = 2'd0;
        e_wdata   = 32'hEEEE_0000;
        m_wdata   = 32'hCCCC_0000;
        w_wdata   = 32'hBBBB_0000;
        mdu_start = 1'b0;
        mdu_div   = 1'b0;
        d_is_mdu  = 1'b0;
    endtask

    task automatic chk_fwd(input string name, input int port, input logic [DW-1:0] exp);
        checks++;
        if (fwd_data[DW*port +: DW] !== exp) begin
            failures++;
            $display("FAIL %s: fwd_data[%0d]=%h expected %h", name, port, fwd_data[DW*port +: DW], exp);
        end
    endtask

    task automatic chk_stall(input string name, input logic exp);
        checks++;
        if (stall !== exp) begin
            failures++;
            $display("FAIL %s: stall=%b expected %b", name, stall, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        #2;
        checks++;
        if (mdu_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: mdu_busy=%b expected 0", mdu_busy);
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt: stall_cnt=%0d expected 0", stall_cnt);
        end
        chk_stall("reset_stall", 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_forward();
        @(negedge clk);
        set_idle();
        rd_addr = {5'd0, 5'd5};
        e_waddr = 5'd5; e_tnew = 2'd0; e_wdata = 32'hAAAA_0001;
        m_waddr = 5'd5; m_tnew = 2'd0;
        #1;
        chk_fwd("fwd_e_over_m", 0, 32'hAAAA_0001);
        chk_stall("fwd_e_over_m_stall", 1'b0);

        e_tnew = 2'd1; rd_tuse = {2'd0, 2'd1};
        #1;
        chk_fwd("fwd_m_when_e_late", 0, 32'hCCCC_0000);
        chk_stall("fwd_e_late_covered", 1'b0);

        set_idle();
        rd_addr = {5'd7, 5'd3};
        w_waddr = 5'd7; m_waddr = 5'd3; m_tnew = 2'd0;
        #1;
        chk_fwd("fwd_m_port0", 0, 32'hCCCC_0000);
        chk_fwd("fwd_w_port1", 1, 32'hBBBB_0000);

        set_idle();
        rd_addr = {5'd9, 5'd4};
        e_waddr = 5'd1; m_waddr = 5'd2; w_waddr = 5'd3;
        #1;
        chk_fwd("fwd_nomatch_p0", 0, 32'h5555_0000);
        chk_fwd("fwd_nomatch_p1", 1, 32'h5555_0001);
    endtask

    task automatic test_reg_zero();
        @(negedge clk);
        set_idle();
        w_wdata = 32'h0000_1234;
        #1;
        chk_fwd("r0_all_zero", 0, 32'h5555_0000);
        chk_stall("r0_all_zero_stall", 1'b0);
        e_tnew = 2'd2; m_tnew = 2'd2;
        #1;
        chk_fwd("r0_busy_prod", 0, 32'h5555_0000);
        chk_stall("r0_no_hazard", 1'b0);
    endtask

    task automatic test_hazard();
        @(negedge clk);
        set_idle();
        rd_addr = {5'd8, 5'd0};
        rd_tuse = {2'd0, 2'd0};
        e_waddr = 5'd8; e_tnew = 2'd1;
        m_waddr = 5'd8; m_tnew = 2'd0;
        #1;
        chk_stall("load_use_e_blocks_m", 1'b1);
        chk_fwd("load_use_fwd_m", 1, 32'hCCCC_0000);

        set_idle();
        rd_addr = {5'd0, 5'd6};
        m_waddr = 5'd6; m_tnew = 2'd2; rd_tuse = {2'd0, 2'd1};
        #1;
        chk_stall("m_late", 1'b1);
        m_tnew = 2'd1;
        #1;
        chk_stall("m_equal_tuse", 1'b0);
    endtask

    task automatic mdu_run(input string name, input logic div, input int lat);
        @(negedge clk);
        set_idle();
        for (int c = 0; c < lat + 3; c++) begin
            logic exp_busy;
            mdu_start = (c == 0 || c == 3);
            mdu_div   = div;
            d_is_mdu  = 1'b1;
            exp_busy  = (c >= 1 && c <= lat);
            #1;
            checks++;
            if (mdu_busy !== exp_busy) begin
                failures++;
                $display("FAIL %s_busy_c%0d: mdu_busy=%b expected %b", name, c, mdu_busy, exp_busy);
            end
            chk_stall($sformatf("%s_stall_c%0d", name, c), exp_busy || mdu_start);
            @(negedge clk);
        end
        set_idle();
    endtask

    task automatic test_mdu();
        mdu_run("div", 1'b1, 10);
        mdu_run("mul", 1'b0, 5);
    endtask

    task automatic test_reset_mid_mdu();
        @(negedge clk);
        set_idle();
        mdu_start = 1'b1;
        @(negedge clk);
        mdu_start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (mdu_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_busy: mdu_busy=%b expected 0", mdu_busy);
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_cnt: stall_cnt=%0d expected 0", stall_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (mdu_busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: mdu_busy=%b expected 0", mdu_busy);
        end
    endtask

    task automatic test_stall_cnt();
        logic [31:0] exp_cnt;
`ifdef BYPASS_STALL_CNT_EN
        exp_cnt = 32'd7;
`else
        exp_cnt = 32'd0;
`endif
        set_idle();
        pulse_reset();
        rd_addr = {5'd8, 5'd0};
        e_waddr = 5'd8; e_tnew = 2'd1;
        repeat (7) @(negedge clk);
        set_idle();
        #1;
        checks++;
        if (stall_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL stall_cnt_7: stall_cnt=%0d expected %0d", stall_cnt, exp_cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL stall_cnt_hold: stall_cnt=%0d expected %0d", stall_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reg_zero();
        test_hazard();
        test_mdu();
        test_reset_mid_mdu();
        test_stall_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
